l2_multi_stream_control: RTL and testbench
==========================================

Name: l2_multi_stream_control

Overview:
- Parametrised successor to the single-stream L2 stream controller; manages n_streams independent prefetch streams sharing one URAM-backed L2 buffer.
- Each stream owns a ring of l2_ncl cache-line slots. The block keeps each ring topped up with OpenCAPI 3.0 read requests, issued under round-robin arbitration.
- It serves tagged L1 read requests by emitting URAM addresses of filled lines.
- It sits between the L1 stream buffers, the L2 URAM read port and the OpenCAPI request/response interface.

Parameters:
- n_streams, 4, number of independent streams (>=1)
- l2_ncl, 256, cache-line slots per stream (power of 2, >=2)
- pf_depth, 256, max lines in flight plus filled per stream (1..l2_ncl)
- id_width, $clog2(n_streams) (min 1), stream id width
- l2_ncl_width, $clog2(l2_ncl), per-stream slot pointer width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_rst_v  in  1  functional stream reset request
- i_rst_id  in  id_width  stream to reset
- i_rst_r  out  1  reset accepted
- i_rd_v  in  1  L1 line read request
- i_rd_id  in  id_width  stream of read
- i_rd_r  out  1  read accepted
- o_addr_v  out  1  URAM read address valid
- o_addr_r  in  1  URAM ready
- o_addr_ptr  out  id_width+l2_ncl_width  {stream id, slot}
- o_req_v  out  1  OpenCAPI request valid
- o_req_r  in  1  OpenCAPI ready
- o_req_id  out  id_width  requesting stream
- o_req_ptr  out  l2_ncl_width  destination slot
- i_rsp_v  in  1  response valid
- i_rsp_id  in  id_width  responding stream
- i_rsp_r  out  1  response ready, tied 1

Behaviour:
- Handshakes: every interface is valid/ready. Transfer occurs on the rising clk edge with v&r high. o_* valids stay high and o_* payloads stay stable until accepted.
- Per-stream state:
  - active (1b)
  - rd_ptr, req_ptr (l2_ncl_width, wrap modulo l2_ncl)
  - issued (count of lines requested but not yet consumed; 0..pf_depth)
  - filled (count of lines responded but not yet consumed; 0..issued)
- Global reset: all streams inactive, all pointers/counters 0, round-robin pointer 0, o_addr_v=0, o_req_v=0, o_addr_ptr=0, o_req_id=0, o_req_ptr=0.
- Functional reset:
  - i_rst_r = (issued[i_rst_id]-filled[i_rst_id]==0), i.e. no responses outstanding for that stream.
  - On transfer: stream set active, and rd_ptr, req_ptr, issued, filled cleared.
  - Resetting an active stream with filled lines discards those lines.
- Read:
  - i_rd_r = active[i_rd_id] & filled[i_rd_id]>0 & (!o_addr_v | o_addr_r) & !(i_rst_v & i_rst_id==i_rd_id).
  - On transfer: o_addr_v=1 next cycle with o_addr_ptr={i_rd_id, rd_ptr}. Then rd_ptr++, filled--, issued--.
  - Latency is 1 cycle; throughput is 1 per cycle when o_addr_r=1.
- Request:
  - A stream is eligible when active & issued<pf_depth & not being functionally reset this cycle.
  - When !o_req_v or the current request transfers, the round-robin arbiter picks the first eligible stream starting at rr_ptr. It loads o_req_id/o_req_ptr=req_ptr[id] and sets o_req_v=1, issued++, req_ptr++, then rr_ptr=id+1 mod n_streams.
  - Credit is consumed at issue into the output register. This prevents double-issue past pf_depth.
- Response: i_rsp_r=1. On transfer, filled[i_rsp_id]++. Responses are in-order per stream.
- Simultaneous events on one stream:
  - Read and issue together: issued unchanged.
  - Read and response together: filled unchanged.
  - Response to an inactive stream, or one that would exceed issued: ignored; an assertion flags it in simulation.
- Reset mid-operation: global reset drops o_addr_v/o_req_v in the same edge, regardless of pending handshakes.
- Wrap: pointers wrap l2_ncl-1 -> 0 with no bubble.

Test Plan:
- Global reset 25 cycles, then i_rst_v id=0 -> i_rst_r=1. Next cycle o_req_v=1, o_req_id=0, o_req_ptr=0. With o_req_r=1, exactly pf_depth requests are issued, then o_req_v=0.
- Reset stream 0, loop req->rsp with 1-cycle delay, then i_rd_v id=0 for 2 cycles -> o_addr_ptr 0x000, 0x001 on consecutive cycles, one cycle after each read transfer.
- Reset streams 0..3 in consecutive cycles, o_req_r=1 -> o_req_id sequence 0,1,2,3,0,1... until each stream issues pf_depth requests.
- pf_depth=4, l2_ncl=4, stream 2: run 10 read/refill cycles -> o_addr_ptr slot sequence 0,1,2,3,0,1,... with id 2. Stream 2 issued never exceeds 4.
- i_rd_v id=1 with filled[1]=0 -> i_rd_r=0, no o_addr_v. i_rst_v id=1 with 3 requests outstanding -> i_rst_r=0 until the third response, then accepted.
- o_addr_r=0 for 5 cycles with a pending address -> o_addr_v and o_addr_ptr held stable, i_rd_r=0. Global reset asserted mid-stall -> o_addr_v=0 next edge.

Source files
------------

// File: rtl/l2_multi_stream_control.sv
// Multi-stream L2 prefetch controller: keeps per-stream URAM line rings topped up with
// round-robin OpenCAPI read requests and turns tagged L1 reads into URAM addresses.
module l2_multi_stream_control #(
    parameter int n_streams    = 4,
    parameter int l2_ncl       = 256,
    parameter int pf_depth     = 256,
    parameter int id_width     = (n_streams > 1) ? $clog2(n_streams) : 1,
    parameter int l2_ncl_width = $clog2(l2_ncl)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_rst_v,
    input  logic [id_width-1:0]              i_rst_id,
    output logic                             i_rst_r,
    input  logic                             i_rd_v,
    input  logic [id_width-1:0]              i_rd_id,
    output logic                             i_rd_r,
    output logic                             o_addr_v,
    input  logic                             o_addr_r,
    output logic [id_width+l2_ncl_width-1:0] o_addr_ptr,
    output logic                             o_req_v,
    input  logic                             o_req_r,
    output logic [id_width-1:0]              o_req_id,
    output logic [l2_ncl_width-1:0]          o_req_ptr,
    input  logic                             i_rsp_v,
    input  logic [id_width-1:0]              i_rsp_id,
    output logic                             i_rsp_r
);
    localparam int cnt_width = $clog2(pf_depth + 1);
    typedef logic [id_width-1:0]     id_t;
    typedef logic [l2_ncl_width-1:0] slot_t;
    typedef logic [cnt_width-1:0]    cnt_t;
    localparam cnt_t pf_max = cnt_t'(pf_depth);

    logic  active_q [n_streams];
    logic  active_d [n_streams];
    slot_t rd_ptr_q [n_streams];
    slot_t rd_ptr_d [n_streams];
    slot_t req_ptr_q[n_streams];
    slot_t req_ptr_d[n_streams];
    cnt_t  issued_q [n_streams];
    cnt_t  issued_d [n_streams];
    cnt_t  filled_q [n_streams];
    cnt_t  filled_d [n_streams];

    id_t                              rr_q, rr_d;
    logic                             addr_v_q, addr_v_d;
    logic [id_width+l2_ncl_width-1:0] addr_ptr_q, addr_ptr_d;
    logic                             req_v_q, req_v_d;
    id_t                              req_id_q, req_id_d;
    slot_t                            req_slot_q, req_slot_d;

    logic                 rst_fire, rd_fire, rsp_ok, req_load, pick_found;
    id_t                  pick_id;
    logic [n_streams-1:0] eligible;

    // A stream may only be reset once every issued line has come back.
    assign i_rst_r  = (issued_q[i_rst_id] - filled_q[i_rst_id]) == '0;
    assign i_rd_r   = active_q[i_rd_id] && (filled_q[i_rd_id] != '0) && (!addr_v_q || o_addr_r)
                      && !(i_rst_v && (i_rst_id == i_rd_id));
    assign i_rsp_r  = 1'b1;
    assign rst_fire = i_rst_v && i_rst_r;
    assign rd_fire  = i_rd_v && i_rd_r;
    assign rsp_ok   = active_q[i_rsp_id] && (filled_q[i_rsp_id] < issued_q[i_rsp_id]);
    assign req_load = !req_v_q || o_req_r;

    assign o_addr_v   = addr_v_q;
    assign o_addr_ptr = addr_ptr_q;
    assign o_req_v    = req_v_q;
    assign o_req_id   = req_id_q;
    assign o_req_ptr  = req_slot_q;

    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int s = 0; s < n_streams; s++) begin
            eligible[s] = active_q[s] && (issued_q[s] < pf_max) && !(i_rst_v && (i_rst_id == id_t'(s)));
        end
        for (int k = 0; k < n_streams; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= n_streams) idx = idx - n_streams;
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick_id    = id_t'(idx);
            end
        end
    end

    always_comb begin
        logic rd_hit, iss_hit, rsp_hit;
        rd_hit     = 1'b0;
        iss_hit    = 1'b0;
        rsp_hit    = 1'b0;
        active_d   = active_q;
        rd_ptr_d   = rd_ptr_q;
        req_ptr_d  = req_ptr_q;
        issued_d   = issued_q;
        filled_d   = filled_q;
        rr_d       = rr_q;
        addr_v_d   = addr_v_q;
        addr_ptr_d = addr_ptr_q;
        req_v_d    = req_v_q;
        req_id_d   = req_id_q;
        req_slot_d = req_slot_q;

        for (int s = 0; s < n_streams; s++) begin
            rd_hit  = rd_fire && (i_rd_id == id_t'(s));
            iss_hit = req_load && pick_found && (pick_id == id_t'(s));
            rsp_hit = i_rsp_v && rsp_ok && (i_rsp_id == id_t'(s));
            if (rst_fire && (i_rst_id == id_t'(s))) begin
                active_d[s]  = 1'b1;
                rd_ptr_d[s]  = '0;
                req_ptr_d[s] = '0;
                issued_d[s]  = '0;
                filled_d[s]  = '0;
            end else begin
                if (rd_hit)  rd_ptr_d[s]  = rd_ptr_q[s] + 1'b1;
                if (iss_hit) req_ptr_d[s] = req_ptr_q[s] + 1'b1;
                if (iss_hit && !rd_hit)      issued_d[s] = issued_q[s] + 1'b1;
                else if (rd_hit && !iss_hit) issued_d[s] = issued_q[s] - 1'b1;
                if (rsp_hit && !rd_hit)      filled_d[s] = filled_q[s] + 1'b1;
                else if (rd_hit && !rsp_hit) filled_d[s] = filled_q[s] - 1'b1;
            end
        end

        if (rd_fire) begin
            addr_v_d   = 1'b1;
            addr_ptr_d = {i_rd_id, rd_ptr_q[i_rd_id]};
        end else if (o_addr_r) begin
            addr_v_d = 1'b0;
        end

        // The credit is taken as the request enters the output register, not at its handshake.
        if (req_load) begin
            req_v_d = pick_found;
            if (pick_found) begin
                req_id_d   = pick_id;
                req_slot_d = req_ptr_q[pick_id];
                rr_d       = (pick_id == id_t'(n_streams - 1)) ? '0 : pick_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the per-stream arrays are plain flops, not RAM, so clearing them in reset is cheap and required.
            for (int s = 0; s < n_streams; s++) begin
                active_q[s]  <= 1'b0;
                rd_ptr_q[s]  <= '0;
                req_ptr_q[s] <= '0;
                issued_q[s]  <= '0;
                filled_q[s]  <= '0;
            end
            rr_q       <= '0;
            addr_v_q   <= 1'b0;
            addr_ptr_q <= '0;
            req_v_q    <= 1'b0;
            req_id_q   <= '0;
            req_slot_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            active_q   <= active_d;
            rd_ptr_q   <= rd_ptr_d;
            req_ptr_q  <= req_ptr_d;
            issued_q   <= issued_d;
            filled_q   <= filled_d;
            rr_q       <= rr_d;
            addr_v_q   <= addr_v_d;
            addr_ptr_q <= addr_ptr_d;
            req_v_q    <= req_v_d;
            req_id_q   <= req_id_d;
            req_slot_q <= req_slot_d;
        end
    end

    // Responses to idle streams or beyond the issued count are dropped; flag them in simulation.
    always_ff @(posedge clk) begin
        if (!reset && i_rsp_v) begin
            rsp_legal_a: assert (rsp_ok);
        end
    end
endmodule

// File: tb/tb_l2_multi_stream_control.sv
// Randomised and directed bench for l2_multi_stream_control, checked against a
// per-stream running-total model of requests, responses and reads.
module tb_l2_multi_stream_control;
    localparam int N   = 4;
    localparam int NCL = 4;
    localparam int PFD = 4;
    localparam int IDW = 2;
    localparam int SW  = 2;
    localparam int PW  = IDW + SW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           i_rst_v, i_rst_r, i_rd_v, i_rd_r;
    logic [IDW-1:0] i_rst_id, i_rd_id, i_rsp_id, o_req_id;
    logic           o_addr_v, o_addr_r, o_req_v, o_req_r, i_rsp_v, i_rsp_r;
    logic [PW-1:0]  o_addr_ptr;
    logic [SW-1:0]  o_req_ptr;

    l2_multi_stream_control #(.n_streams(N), .l2_ncl(NCL), .pf_depth(PFD)) dut (
        .clk(clk), .reset(reset),
        .i_rst_v(i_rst_v), .i_rst_id(i_rst_id), .i_rst_r(i_rst_r),
        .i_rd_v(i_rd_v), .i_rd_id(i_rd_id), .i_rd_r(i_rd_r),
        .o_addr_v(o_addr_v), .o_addr_r(o_addr_r), .o_addr_ptr(o_addr_ptr),
        .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_id(o_req_id), .o_req_ptr(o_req_ptr),
        .i_rsp_v(i_rsp_v), .i_rsp_id(i_rsp_id), .i_rsp_r(i_rsp_r)
    );

    always #5 clk = ~clk;

    int tests, fails;

    // Model: running totals since the last stream reset; slots are totals modulo NCL.
    bit m_active[N];
    int m_iss[N], m_rsp[N], m_rd[N], m_xfer[N];
    bit m_addr_v, m_req_v;
    int m_addr_id, m_addr_slot, m_req_id, m_req_slot, m_rr;

    function automatic bit pending(int s);
        return m_active[s] && (m_rsp[s] < m_xfer[s]);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < N; s++) begin
            m_active[s] = 0; m_iss[s] = 0; m_rsp[s] = 0; m_rd[s] = 0; m_xfer[s] = 0;
        end
        m_addr_v = 0; m_addr_id = 0; m_addr_slot = 0;
        m_req_v = 0; m_req_id = 0; m_req_slot = 0; m_rr = 0;
    endtask

    task automatic set_idle();
        i_rst_v = 0; i_rst_id = '0; i_rd_v = 0; i_rd_id = '0; o_addr_r = 1;
        o_req_r = 0; i_rsp_v = 0; i_rsp_id = '0;
    endtask

    // One clock: compare DUT outputs with the model, advance the model, step past the edge.
    task automatic cycle();
        bit e_rst_r, e_rd_r, rst_fire, rd_fire, rsp_fire, load, xfer, found;
        int rid, did, pid, pick, s;
        logic [PW-1:0]  e_aptr;
        logic [IDW-1:0] e_id;
        logic [SW-1:0]  e_slot;
        #2;
        rid = int'(i_rst_id); did = int'(i_rd_id); pid = int'(i_rsp_id);
        e_rst_r = (m_iss[rid] - m_rsp[rid]) == 0;
        e_rd_r  = m_active[did] && (m_rsp[did] > m_rd[did]) && (!m_addr_v || o_addr_r)
                  && !(i_rst_v && rid == did);
        e_aptr = PW'(m_addr_id * NCL + m_addr_slot);
        e_id   = IDW'(m_req_id);
        e_slot = SW'(m_req_slot);
        tests += 5;
        if (i_rst_r !== e_rst_r) begin fails++; $display("FAIL rst_ready: got %b want %b at %0t", i_rst_r, e_rst_r, $time); end
        if (i_rd_r !== e_rd_r) begin fails++; $display("FAIL rd_ready: got %b want %b at %0t", i_rd_r, e_rd_r, $time); end
        if (i_rsp_r !== 1'b1) begin fails++; $display("FAIL rsp_ready: got %b want 1 at %0t", i_rsp_r, $time); end
        if (o_addr_v !== m_addr_v) begin fails++; $display("FAIL addr_valid: got %b want %b at %0t", o_addr_v, m_addr_v, $time); end
        if (o_req_v !== m_req_v) begin fails++; $display("FAIL req_valid: got %b want %b at %0t", o_req_v, m_req_v, $time); end
        if (m_addr_v) begin
            tests++;
            if (o_addr_ptr !== e_aptr) begin fails++; $display("FAIL addr_ptr: got %h want %h at %0t", o_addr_ptr, e_aptr, $time); end
        end
        if (m_req_v) begin
            tests += 2;
            if (o_req_id !== e_id) begin fails++; $display("FAIL req_id: got %0d want %0d at %0t", o_req_id, e_id, $time); end
            if (o_req_ptr !== e_slot) begin fails++; $display("FAIL req_ptr: got %0d want %0d at %0t", o_req_ptr, e_slot, $time); end
        end

        if (reset) begin
            model_clear();
        end else begin
            rst_fire = i_rst_v && e_rst_r;
            rd_fire  = i_rd_v && e_rd_r;
            rsp_fire = i_rsp_v && m_active[pid] && (m_rsp[pid] < m_iss[pid]);
            load     = !m_req_v || o_req_r;
            xfer     = m_req_v && o_req_r;
            found = 0; pick = 0;
            for (int k = 0; k < N; k++) begin
                s = (m_rr + k) % N;
                if (!found && m_active[s] && (m_iss[s] - m_rd[s]) < PFD && !(i_rst_v && rid == s)) begin
                    found = 1; pick = s;
                end
            end
            if (xfer) m_xfer[m_req_id]++;
            if (rd_fire) begin
                m_addr_v = 1; m_addr_id = did; m_addr_slot = m_rd[did] % NCL; m_rd[did]++;
            end else if (o_addr_r) begin
                m_addr_v = 0;
            end
            if (rsp_fire) m_rsp[pid]++;
            if (load) begin
                m_req_v = found;
                if (found) begin
                    m_req_id = pick; m_req_slot = m_iss[pick] % NCL; m_iss[pick]++; m_rr = (pick + 1) % N;
                end
            end
            if (rst_fire) begin
                m_active[rid] = 1; m_iss[rid] = 0; m_rsp[rid] = 0; m_rd[rid] = 0; m_xfer[rid] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        repeat (25) @(posedge clk);
        #1;
        model_clear();
        tests += 6;
        if (o_addr_v !== 1'b0) begin fails++; $display("FAIL reset_addr_v: got %b want 0", o_addr_v); end
        if (o_req_v !== 1'b0) begin fails++; $display("FAIL reset_req_v: got %b want 0", o_req_v); end
        if (o_addr_ptr !== '0) begin fails++; $display("FAIL reset_addr_ptr: got %h want 0", o_addr_ptr); end
        if (o_req_id !== '0) begin fails++; $display("FAIL reset_req_id: got %0d want 0", o_req_id); end
        if (o_req_ptr !== '0) begin fails++; $display("FAIL reset_req_ptr: got %0d want 0", o_req_ptr); end
        if (i_rsp_r !== 1'b1) begin fails++; $display("FAIL reset_rsp_r: got %b want 1", i_rsp_r); end
        reset = 0;
    endtask

    task automatic test_fill();
        int n;
        set_idle();
        i_rst_v = 1; i_rst_id = 0;
        #1;
        tests++;
        if (i_rst_r !== 1'b1) begin fails++; $display("FAIL fill_rst_accept: got %b want 1", i_rst_r); end
        cycle();
        i_rst_v = 0;
        cycle();
        tests += 3;
        if (o_req_v !== 1'b1) begin fails++; $display("FAIL fill_first_v: got %b want 1", o_req_v); end
        if (o_req_id !== 2'd0) begin fails++; $display("FAIL fill_first_id: got %0d want 0", o_req_id); end
        if (o_req_ptr !== 2'd0) begin fails++; $display("FAIL fill_first_ptr: got %0d want 0", o_req_ptr); end
        o_req_r = 1; n = 0;
        repeat (20) begin
            if (o_req_v && o_req_id == 0) n++;
            cycle();
        end
        tests += 2;
        if (n != PFD) begin fails++; $display("FAIL fill_count: got %0d want %0d", n, PFD); end
        if (o_req_v !== 1'b0) begin fails++; $display("FAIL fill_stop: got %b want 0", o_req_v); end
        o_req_r = 0;
    endtask

    task automatic test_read();
        set_idle();
        i_rsp_id = 0;
        repeat (PFD) begin i_rsp_v = pending(0); cycle(); end
        i_rsp_v = 0;
        i_rst_v = 1; i_rst_id = 0;
        #1;
        tests++;
        if (i_rst_r !== 1'b1) begin fails++; $display("FAIL read_rst_accept: got %b want 1", i_rst_r); end
        cycle();
        i_rst_v = 0;
        o_req_r = 1;
        repeat (10) begin i_rsp_v = pending(0); cycle(); end
        i_rsp_v = 0; o_req_r = 0;
        i_rd_v = 1; i_rd_id = 0;
        cycle();
        tests += 2;
        if (o_addr_v !== 1'b1) begin fails++; $display("FAIL read_first_v: got %b want 1", o_addr_v); end
        if (o_addr_ptr !== 4'h0) begin fails++; $display("FAIL read_first_ptr: got %h want 0", o_addr_ptr); end
        cycle();
        tests += 2;
        if (o_addr_v !== 1'b1) begin fails++; $display("FAIL read_second_v: got %b want 1", o_addr_v); end
        if (o_addr_ptr !== 4'h1) begin fails++; $display("FAIL read_second_ptr: got %h want 1", o_addr_ptr); end
        i_rd_v = 0;
        cycle();
    endtask

    task automatic test_round_robin();
        int seq;
        set_idle();
        reset = 1; cycle(); reset = 0;
        o_req_r = 1; seq = 0;
        for (int c = 0; c < 60; c++) begin
            i_rst_v = (c < N); i_rst_id = IDW'(c % N);
            if (o_req_v) begin
                tests++;
                if (o_req_id !== IDW'(seq % N)) begin fails++; $display("FAIL rr_order: got %0d want %0d at grant %0d", o_req_id, seq % N, seq); end
                seq++;
            end
            cycle();
        end
        i_rst_v = 0;
        tests++;
        if (seq != N * PFD) begin fails++; $display("FAIL rr_total: got %0d want %0d", seq, N * PFD); end
        o_req_r = 0;
    endtask

    task automatic test_wrap();
        int n, nx, nr;
        set_idle();
        reset = 1; cycle(); reset = 0;
        i_rst_v = 1; i_rst_id = 2; cycle(); i_rst_v = 0;
        o_req_r = 1; i_rd_v = 1; i_rd_id = 2; i_rsp_id = 2;
        n = 0; nx = 0; nr = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            i_rsp_v = pending(2);
            #1;
            if (o_addr_v) begin
                tests++;
                if (o_addr_ptr !== PW'(2 * NCL + n % NCL)) begin fails++; $display("FAIL wrap_ptr: got %h want %h", o_addr_ptr, PW'(2 * NCL + n % NCL)); end
                n++;
            end
            if (o_req_v && o_req_id == 2) nx++;
            if (i_rd_r) nr++;
            tests++;
            if (nx - nr > PFD) begin fails++; $display("FAIL wrap_depth: got %0d outstanding want at most %0d", nx - nr, PFD); end
            cycle();
        end
        tests++;
        if (n != 10) begin fails++; $display("FAIL wrap_count: got %0d want 10", n); end
        set_idle();
    endtask

    task automatic test_reject();
        int acc;
        set_idle();
        reset = 1; cycle(); reset = 0;
        i_rst_v = 1; i_rst_id = 1; cycle(); i_rst_v = 0;
        i_rd_v = 1; i_rd_id = 1;
        #1;
        tests++;
        if (i_rd_r !== 1'b0) begin fails++; $display("FAIL reject_rd_r: got %b want 0", i_rd_r); end
        cycle();
        i_rd_v = 0;
        tests++;
        if (o_addr_v !== 1'b0) begin fails++; $display("FAIL reject_addr_v: got %b want 0", o_addr_v); end
        o_req_r = 1; repeat (8) cycle(); o_req_r = 0;
        i_rsp_v = 1; i_rsp_id = 1; cycle(); i_rsp_v = 0;
        i_rst_v = 1; i_rst_id = 1; acc = -1;
        for (int k = 0; k < 10 && acc < 0; k++) begin
            i_rsp_v = pending(1);
            #1;
            if (i_rst_r) acc = k;
            cycle();
        end
        i_rst_v = 0; i_rsp_v = 0;
        tests++;
        if (acc != 3) begin fails++; $display("FAIL reject_rst_wait: got accept at %0d want 3", acc); end
    endtask

    task automatic test_stall();
        logic [PW-1:0] held;
        set_idle();
        o_req_r = 1; i_rsp_id = 1;
        repeat (12) begin i_rsp_v = pending(1); cycle(); end
        i_rsp_v = 0; o_req_r = 0;
        o_addr_r = 0; i_rd_v = 1; i_rd_id = 1;
        cycle();
        tests += 2;
        if (o_addr_v !== 1'b1) begin fails++; $display("FAIL stall_v: got %b want 1", o_addr_v); end
        if (o_addr_ptr !== 4'h4) begin fails++; $display("FAIL stall_ptr: got %h want 4", o_addr_ptr); end
        held = o_addr_ptr;
        repeat (5) begin
            #1;
            tests += 3;
            if (i_rd_r !== 1'b0) begin fails++; $display("FAIL stall_rd_r: got %b want 0", i_rd_r); end
            if (o_addr_v !== 1'b1) begin fails++; $display("FAIL stall_hold_v: got %b want 1", o_addr_v); end
            if (o_addr_ptr !== held) begin fails++; $display("FAIL stall_hold_ptr: got %h want %h", o_addr_ptr, held); end
            cycle();
        end
        reset = 1;
        cycle();
        tests += 2;
        if (o_addr_v !== 1'b0) begin fails++; $display("FAIL stall_reset_addr_v: got %b want 0", o_addr_v); end
        if (o_req_v !== 1'b0) begin fails++; $display("FAIL stall_reset_req_v: got %b want 0", o_req_v); end
        reset = 0;
        set_idle();
    endtask

    task automatic test_random();
        int s;
        set_idle();
        for (int k = 0; k < N; k++) begin
            i_rst_v = 1; i_rst_id = IDW'(k); cycle();
        end
        i_rst_v = 0;
        for (int c = 0; c < 800; c++) begin
            reset    = (c == 400);
            o_req_r  = ($urandom_range(0, 3) != 0);
            o_addr_r = ($urandom_range(0, 3) != 0);
            i_rd_v   = 1'($urandom_range(0, 1));
            i_rd_id  = IDW'($urandom_range(0, N - 1));
            s        = int'($urandom_range(0, N - 1));
            i_rsp_id = IDW'(s);
            i_rsp_v  = pending(s) && ($urandom_range(0, 2) != 0);
            i_rst_v  = ($urandom_range(0, 24) == 0);
            i_rst_id = IDW'($urandom_range(0, N - 1));
            cycle();
        end
        reset = 0;
        set_idle();
    endtask

    initial begin
        tests = 0; fails = 0;
        set_idle();
        model_clear();
        test_reset();
        test_fill();
        test_read();
        test_round_robin();
        test_wrap();
        test_reject();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule
